// File: rtl/mole_pkg.sv
// mole_pkg: shared scorer state type, score/miss constants and saturating BCD adder
package mole_pkg;

    typedef enum logic [1:0] {IDLE, PLAY, OVER} scorer_state_t;
    typedef logic [3:0] bcd_digit_t;

    localparam logic [11:0] SCORE_MAX_BCD = 12'h999;
    localparam int          MISS_W        = 4;

    function automatic logic [11:0] bcd_add_sat(input logic [11:0] s, input logic [3:0] n);
        logic [4:0] d0, d1, d2;
        logic       c0, c1;
        d0 = 5'(s[3:0]) + 5'(n);
        c0 = d0 > 5'd9;
        d0 = c0 ? d0 - 5'd10 : d0;
        d1 = 5'(s[7:4]) + 5'(c0);
        c1 = d1 > 5'd9;
        d1 = c1 ? d1 - 5'd10 : d1;
        d2 = 5'(s[11:8]) + 5'(c1);
        return (d2 > 5'd9) ? SCORE_MAX_BCD : {d2[3:0], d1[3:0], d0[3:0]};
    endfunction

endpackage

// File: rtl/mole_button_edge.sv
// mole_button_edge: two-flop button synchroniser followed by a rising-edge detector
module mole_button_edge (
    input  logic clk,
    input  logic reset,
    input  logic btn_i,
    output logic press_o
);

    logic [2:0] sh_q;

    always_ff @(posedge clk) begin
        if (reset) sh_q <= '0;
        else       sh_q <= {sh_q[1:0], btn_i};
    end

    assign press_o = sh_q[1] & ~sh_q[2];

endmodule

// File: rtl/mole_hit_scorer.sv
// mole_hit_scorer: hit/escape scoring and IDLE/PLAY/OVER game FSM; EMPTY_WHACK_PENALTY_EN charges presses on unlit moles as misses
module mole_hit_scorer
    import mole_pkg::*;
#(
    parameter int NUM_MOLES  = 4,
    parameter int MAX_MISSES = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [NUM_MOLES-1:0] led_on,
    input  logic [NUM_MOLES-1:0] button,
    output logic [11:0]          score_bcd,
    output logic [MISS_W-1:0]    misses,
    output logic                 hit,
    output logic                 playing,
    output logic                 game_over
);

    scorer_state_t         state_q, state_d;
    logic [11:0]           score_q, score_d;
    logic [MISS_W-1:0]     misses_q, misses_d;
    logic [NUM_MOLES-1:0]  led_q, armed_q, armed_d;
    logic [NUM_MOLES-1:0]  press, rise, fall, hit_v, miss_raw, miss_v;
    logic [4:0]            miss_sum;
    logic                  hit_q, playing_q, over_q, in_play;

    for (genvar i = 0; i < NUM_MOLES; i++) begin : g_btn
        mole_button_edge u_btn (
            .clk     (clk),
            .reset   (reset),
            .btn_i   (button[i]),
            .press_o (press[i])
        );
    end

    assign rise    = led_on & ~led_q;
    assign fall    = ~led_on & led_q;
    assign in_play = (state_q == PLAY) && !start;

`ifdef EMPTY_WHACK_PENALTY_EN
    assign miss_raw = (fall & armed_q) | (press & ~led_on & ~fall);
`else
    assign miss_raw = fall & armed_q;
`endif

    assign hit_v  = in_play ? (press & led_on & armed_q) : '0;
    assign miss_v = in_play ? miss_raw : '0;

    // start always wins: it clears the game and (re)enters PLAY from any state
    always_comb begin
        miss_sum = 5'(misses_q) + 5'($countones(miss_v));
        score_d  = start ? '0 : bcd_add_sat(score_q, 4'($countones(hit_v)));
        misses_d = start ? '0
                 : (miss_sum >= 5'(MAX_MISSES)) ? MISS_W'(MAX_MISSES) : miss_sum[MISS_W-1:0];
        state_d  = start ? PLAY
                 : (state_q == PLAY && miss_sum >= 5'(MAX_MISSES)) ? OVER : state_q;
        armed_d  = (state_d == PLAY && !start) ? (rise | (armed_q & ~hit_v & ~fall)) : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            score_q   <= '0;
            misses_q  <= '0;
            led_q     <= '0;
            armed_q   <= '0;
            hit_q     <= 1'b0;
            playing_q <= 1'b0;
            over_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            score_q   <= score_d;
            misses_q  <= misses_d;
            led_q     <= led_on;
            armed_q   <= armed_d;
            hit_q     <= |hit_v;
            playing_q <= state_d == PLAY;
            over_q    <= state_d == OVER;
        end
    end

    assign score_bcd = score_q;
    assign misses    = misses_q;
    assign hit       = hit_q;
    assign playing   = playing_q;
    assign game_over = over_q;

endmodule
